// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad emulator.
//   state_e   - press-sequence FSM states
//   IDLE_COL  - column value with no switch closed (all lines pulled high)
//   key_to_rc - key code -> {row[1:0], col[1:0]} position on the keypad
//   rc_to_key - inverse of key_to_rc, used to decode an observed row/column
// Layout (row 0 is the top row, col 0 the left column):
//   row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: 0 F E D
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_e;

  localparam logic [3:0] IDLE_COL = 4'hF;

  // Returns {row, col} of the switch that carries the given key code.
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      4'h1:    rc = 4'b00_00;
      4'h2:    rc = 4'b00_01;
      4'h3:    rc = 4'b00_10;
      4'hA:    rc = 4'b00_11;
      4'h4:    rc = 4'b01_00;
      4'h5:    rc = 4'b01_01;
      4'h6:    rc = 4'b01_10;
      4'hB:    rc = 4'b01_11;
      4'h7:    rc = 4'b10_00;
      4'h8:    rc = 4'b10_01;
      4'h9:    rc = 4'b10_10;
      4'hC:    rc = 4'b10_11;
      4'h0:    rc = 4'b11_00;
      4'hF:    rc = 4'b11_01;
      4'hE:    rc = 4'b11_10;
      4'hD:    rc = 4'b11_11;
      default: rc = 4'b00_00;
    endcase
    return rc;
  endfunction

  // Returns the key code found at the given row/column position.
  function automatic logic [3:0] rc_to_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_phase_timer.sv
// keypad_phase_timer: loadable down-counter shared by every press phase.
// A phase of N cycles loads N-1 on entry; the phase ends on the cycle the
// counter reads zero. The counter holds at zero, so it never wraps.
// Ports:
//   clk_i      - system clock
//   rst_i      - asynchronous active-high reset (counter -> 0)
//   load_i     - load load_val_i on the next edge
//   load_val_i - value to load (phase length minus one)
//   cnt_o      - current count
//   zero_o     - count is zero
module keypad_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Counter register: load has priority, otherwise count down until zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: stands in for a physical 4x4 matrix keypad.
// A requested key is "pressed" for a fixed time, optionally with contact
// bounce on make and break, then released for a gap before the next request.
// While the contact is closed the column of that key follows the scanner's
// drive on the key's row, combinationally, exactly like a closed switch.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   row       - scanner row drive, active-low
//   col       - column sense back to the scanner, active-low, idle 4'hF
//   key_valid - press request
//   key_code  - hex code of the key to press
//   key_ready - request can be accepted (idle)
//   pressed   - contact currently closed
//   done      - one-cycle pulse on the last released cycle of a press
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1000,
  parameter int GAP_CYCLES    = 1000,
  parameter int BOUNCE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       pressed,
  output logic       done
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_N  = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
  localparam int CW     = $clog2(MAX_N + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BNC_LD  = CW'((BOUNCE_CYCLES > 0) ? (BOUNCE_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic          BOUNCE_EN = (BOUNCE_CYCLES > 0);
  localparam logic          GAP_ONE   = (GAP_CYCLES == 1);

  state_e      state_q, state_d;
  logic [3:0]  key_q, key_d;
  logic        contact_q, contact_d;
  logic        done_q, done_d;

  logic          load_s;
  logic [CW-1:0] load_val_s;
  logic [CW-1:0] cnt_s;
  logic          zero_s;
  logic [3:0]    rc_s;
  logic [3:0]    col_s;

  keypad_phase_timer #(.W(CW)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .cnt_o      (cnt_s),
    .zero_o     (zero_s)
  );

  // Next-state logic: phase sequencing, contact pattern and done look-ahead.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    contact_d  = contact_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    load_val_s = {CW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          key_d     = key_code;
          contact_d = 1'b1;
          load_s    = 1'b1;
          if (BOUNCE_EN) begin
            state_d    = ST_BOUNCE_IN;
            load_val_s = BNC_LD;
          end else begin
            state_d    = ST_HOLD;
            load_val_s = HOLD_LD;
          end
        end else begin
          contact_d = 1'b0;
        end
      end
      ST_BOUNCE_IN: begin
        if (zero_s) begin
          state_d    = ST_HOLD;
          contact_d  = 1'b1;
          load_s     = 1'b1;
          load_val_s = HOLD_LD;
        end else begin
          contact_d = ~contact_q;
        end
      end
      ST_HOLD: begin
        if (zero_s) begin
          contact_d = 1'b0;
          load_s    = 1'b1;
          if (BOUNCE_EN) begin
            state_d    = ST_BOUNCE_OUT;
            load_val_s = BNC_LD;
          end else begin
            state_d    = ST_GAP;
            load_val_s = GAP_LD;
            done_d     = GAP_ONE;
          end
        end else begin
          contact_d = 1'b1;
        end
      end
      ST_BOUNCE_OUT: begin
        if (zero_s) begin
          state_d    = ST_GAP;
          contact_d  = 1'b0;
          load_s     = 1'b1;
          load_val_s = GAP_LD;
          done_d     = GAP_ONE;
        end else begin
          contact_d = ~contact_q;
        end
      end
      ST_GAP: begin
        contact_d = 1'b0;
        if (zero_s) begin
          state_d = ST_IDLE;
        end else begin
          // done is registered, so raise it one cycle ahead of the last GAP cycle
          done_d = (cnt_s == CNT_ONE);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops the contact at once so col floats back high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_q     <= 4'h0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  assign rc_s = key_to_rc(key_q);

  // Single-switch column model: only the stored key's column can be pulled low.
  always_comb begin
    col_s = IDLE_COL;
    if (contact_q && (row[rc_s[3:2]] == 1'b0)) begin
      col_s[rc_s[1:0]] = 1'b0;
    end else begin
      col_s = IDLE_COL;
    end
  end

  assign col       = col_s;
  assign key_ready = (state_q == ST_IDLE);
  assign pressed   = contact_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: self-checking bench for keypad_emulator.
// dut0: HOLD=4, GAP=3, BOUNCE=0.  dut1: HOLD=2, GAP=3, BOUNCE=3.
// Expected values come from a cycle-offset model of the press sequence and an
// independent copy of the key layout.
module tb_keypad_emulator;
  import keypad_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] row_v [2];
  logic       kv_v  [2];
  logic [3:0] kc_v  [2];
  logic [3:0] col_v [2];
  logic       rdy_v [2];
  logic       prs_v [2];
  logic       dn_v  [2];

  int n_tests = 0;
  int n_fail  = 0;

  keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .BOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .row(row_v[0]), .col(col_v[0]),
    .key_valid(kv_v[0]), .key_code(kc_v[0]), .key_ready(rdy_v[0]),
    .pressed(prs_v[0]), .done(dn_v[0])
  );

  keypad_emulator #(.HOLD_CYCLES(2), .GAP_CYCLES(3), .BOUNCE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .row(row_v[1]), .col(col_v[1]),
    .key_valid(kv_v[1]), .key_code(kc_v[1]), .key_ready(rdy_v[1]),
    .pressed(prs_v[1]), .done(dn_v[1])
  );

  // ---------------- reference model ----------------
  function automatic int hold_of(input int sel); return (sel == 0) ? 4 : 2; endfunction
  function automatic int gap_of(input int sel);  return 3; endfunction
  function automatic int bnc_of(input int sel);  return (sel == 0) ? 0 : 3; endfunction
  function automatic int period(input int sel);
    return 2 * bnc_of(sel) + hold_of(sel) + gap_of(sel);
  endfunction

  // Contact state t cycles after the accepting edge (t=1 is the first press cycle).
  function automatic logic exp_contact(input int sel, input int t);
    int b = bnc_of(sel);
    int h = hold_of(sel);
    if (t <= 0) return 1'b0;
    if (t <= b) return ((t - 1) % 2) == 0;
    if (t <= b + h) return 1'b1;
    if (t <= 2 * b + h) return ((t - b - h - 1) % 2) == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] lay(input int r, input int c);
    logic [15:0] w;
    case (r)
      0: w = 16'h123A;
      1: w = 16'h456B;
      2: w = 16'h789C;
      default: w = 16'h0FED;
    endcase
    return w[15 - 4 * c -: 4];
  endfunction

  function automatic logic [3:0] exp_col(input logic [3:0] code, input logic contact,
                                         input logic [3:0] row);
    logic [3:0] res;
    res = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (lay(r, c) == code && contact && row[r] == 1'b0) res[c] = 1'b0;
    return res;
  endfunction

  // ---------------- stimulus ----------------
  task automatic accept(input int sel, input logic [3:0] code, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    kv_v[sel] = 1'b1;
    kc_v[sel] = code;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (rdy_v[sel] === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    kv_v[sel] = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: dut%0d key_ready=%b required 1", sel, rdy_v[sel]);
    end
  endtask

  // One full press, checked every cycle. mode 0: one-cold rotating rows,
  // 1: random rows, 2: fixed row value.
  task automatic run_press(input int sel, input logic [3:0] code, input int mode,
                           input logic [3:0] fixed_row, output int pcount,
                           output int done_t, output int ready_t,
                           output logic [3:0] rec, output bit got);
    bit ok;
    int p;
    logic ec;
    logic [3:0] one, rw, ecol;
    int rr, cc;
    pcount = 0; done_t = -1; ready_t = -1; rec = 4'h0; got = 1'b0;
    one = 4'b0001;
    accept(sel, code, ok);
    if (ok) begin
      p = period(sel);
      for (int t = 1; t <= p + 1; t++) begin
        case (mode)
          0: rw = ~(one << (t % 4));
          1: rw = 4'($urandom);
          default: rw = fixed_row;
        endcase
        row_v[sel] = rw;
        #1;
        ec   = exp_contact(sel, t);
        ecol = exp_col(code, ec, rw);
        n_tests++;
        if (col_v[sel] !== ecol) begin
          n_fail++;
          $display("FAIL press_col: dut%0d key=%h t=%0d row=%b col=%b required %b",
                   sel, code, t, rw, col_v[sel], ecol);
        end
        n_tests++;
        if (prs_v[sel] !== ec) begin
          n_fail++;
          $display("FAIL press_pressed: dut%0d key=%h t=%0d got %b required %b",
                   sel, code, t, prs_v[sel], ec);
        end
        n_tests++;
        if (dn_v[sel] !== (t == p)) begin
          n_fail++;
          $display("FAIL press_done: dut%0d key=%h t=%0d got %b required %b",
                   sel, code, t, dn_v[sel], (t == p));
        end
        n_tests++;
        if (rdy_v[sel] !== (t > p)) begin
          n_fail++;
          $display("FAIL press_ready: dut%0d key=%h t=%0d got %b required %b",
                   sel, code, t, rdy_v[sel], (t > p));
        end
        if (prs_v[sel] === 1'b1) pcount++;
        if (dn_v[sel] === 1'b1 && done_t < 0) done_t = t;
        if (rdy_v[sel] === 1'b1 && ready_t < 0) ready_t = t;
        if (col_v[sel] != 4'hF && $countones(~rw) == 1) begin
          rr = 0; cc = 0;
          for (int i = 0; i < 4; i++) begin
            if (rw[i] == 1'b0) rr = i;
            if (col_v[sel][i] == 1'b0) cc = i;
          end
          rec = rc_to_key(2'(rr), 2'(cc));
          got = 1'b1;
        end
        @(negedge clk);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      row_v[s] = 4'b0000; kv_v[s] = 1'b0; kc_v[s] = 4'h0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (rdy_v[s] !== 1'b1 || prs_v[s] !== 1'b0 || dn_v[s] !== 1'b0 || col_v[s] !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_state: dut%0d ready=%b pressed=%b done=%b col=%b required 1 0 0 1111",
                 s, rdy_v[s], prs_v[s], dn_v[s], col_v[s]);
      end
    end
    // Reset in the middle of HOLD with key 5 pressed.
    row_v[0] = 4'b1101;
    accept(0, 4'h5, ok);
    @(negedge clk);
    #1;
    n_tests++;
    if (col_v[0] !== 4'b1101) begin
      n_fail++;
      $display("FAIL reset_midhold_col: got %b required 1101", col_v[0]);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (col_v[0] !== 4'hF || prs_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: col=%b pressed=%b required 1111 0", col_v[0], prs_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rdy_v[0] !== 1'b1 || col_v[0] !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b col=%b required 1 1111", rdy_v[0], col_v[0]);
    end
  endtask

  task automatic test_basic();
    int pc, dt, rt; logic [3:0] rec; bit got;
    run_press(0, 4'h9, 0, 4'hF, pc, dt, rt, rec, got);
    n_tests++;
    if (pc !== 4) begin n_fail++; $display("FAIL basic_press_len: got %0d required 4", pc); end
    n_tests++;
    if (dt !== 7) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 7", dt); end
    n_tests++;
    if (rt !== 8) begin n_fail++; $display("FAIL basic_ready_cycle: got %0d required 8", rt); end
  endtask

  task automatic test_full_map();
    int pc, dt, rt; logic [3:0] rec; bit got;
    for (int k = 0; k < 16; k++) begin
      run_press(0, 4'(k), 0, 4'hF, pc, dt, rt, rec, got);
      n_tests++;
      if (!got || rec !== 4'(k)) begin
        n_fail++;
        $display("FAIL full_map: sent %h recovered %h (seen=%0d) required %h", k, rec, got, k);
      end
    end
  endtask

  task automatic test_bounce();
    bit ok;
    logic exp0 [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    row_v[1] = 4'b1110;
    accept(1, 4'h1, ok);
    if (ok) begin
      for (int t = 1; t <= 11; t++) begin
        #1;
        n_tests++;
        if (col_v[1] !== {3'b111, exp0[t-1]}) begin
          n_fail++;
          $display("FAIL bounce_col: t=%0d col=%b required %b", t, col_v[1], {3'b111, exp0[t-1]});
        end
        n_tests++;
        if (dn_v[1] !== (t == 11)) begin
          n_fail++;
          $display("FAIL bounce_done: t=%0d got %b required %b", t, dn_v[1], (t == 11));
        end
        @(negedge clk);
      end
      n_tests++;
      if (rdy_v[1] !== 1'b1) begin
        n_fail++; $display("FAIL bounce_ready: got %b required 1", rdy_v[1]);
      end
    end
  endtask

  task automatic test_busy();
    bit ok;
    int p;
    logic [3:0] ecol;
    p = period(0);
    row_v[0] = 4'b0000;
    accept(0, 4'hD, ok);
    if (ok) begin
      kv_v[0] = 1'b1;
      kc_v[0] = 4'h4;
      for (int t = 1; t <= p; t++) begin
        #1;
        ecol = exp_col(4'hD, exp_contact(0, t), 4'b0000);
        n_tests++;
        if (rdy_v[0] !== 1'b0 || col_v[0] !== ecol) begin
          n_fail++;
          $display("FAIL busy_hold: t=%0d ready=%b col=%b required 0 %b", t, rdy_v[0], col_v[0], ecol);
        end
        @(negedge clk);
      end
      n_tests++;
      if (rdy_v[0] !== 1'b1) begin
        n_fail++; $display("FAIL busy_ready: got %b required 1", rdy_v[0]);
      end
      @(negedge clk);
      kv_v[0] = 1'b0;
      #1;
      n_tests++;
      if (col_v[0] !== 4'b1110) begin
        n_fail++; $display("FAIL busy_second_key: col=%b required 1110", col_v[0]);
      end
      repeat (p) @(negedge clk);
      n_tests++;
      if (rdy_v[0] !== 1'b1) begin
        n_fail++; $display("FAIL busy_end_ready: got %b required 1", rdy_v[0]);
      end
    end
  endtask

  task automatic test_multi_row();
    bit ok;
    row_v[0] = 4'b0000;
    accept(0, 4'hE, ok);
    if (ok) begin
      #1;
      n_tests++;
      if (col_v[0] !== 4'b1011) begin
        n_fail++; $display("FAIL multirow_all_low: col=%b required 1011", col_v[0]);
      end
      row_v[0] = 4'hF;
      #1;
      n_tests++;
      if (col_v[0] !== 4'hF) begin
        n_fail++; $display("FAIL multirow_none_low: col=%b required 1111", col_v[0]);
      end
      row_v[0] = 4'b0110;
      #1;
      n_tests++;
      if (col_v[0] !== 4'b1011) begin
        n_fail++; $display("FAIL multirow_row3: col=%b required 1011", col_v[0]);
      end
      repeat (period(0)) @(negedge clk);
      n_tests++;
      if (rdy_v[0] !== 1'b1) begin
        n_fail++; $display("FAIL multirow_ready: got %b required 1", rdy_v[0]);
      end
    end
  endtask

  task automatic test_random();
    int pc, dt, rt; logic [3:0] rec; bit got;
    int sel;
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_press(sel, 4'($urandom), 1, 4'hF, pc, dt, rt, rec, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_map();
    test_bounce();
    test_busy();
    test_multi_row();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
